// File: rtl/fir_section_pkg.sv
// Fixed-point formats, helpers and FSM encoding for the time-multiplexed FIR section.
// Words are Q3.12, and products are rescaled back to the same 12-bit fraction.
package fir_section_pkg;

    localparam int WORD_SIZE    = 16;
    localparam int FRAC_BITS    = 12;
    localparam int PRODUCT_SIZE = 2*WORD_SIZE - FRAC_BITS;
    localparam int ACCUM_SIZE   = PRODUCT_SIZE + 1;

    typedef logic signed [WORD_SIZE-1:0]    word_t;
    typedef logic signed [PRODUCT_SIZE-1:0] prod_t;
    typedef logic signed [ACCUM_SIZE-1:0]   accum_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Narrow an accumulator-format value to a word, clamping at the word range.
    function automatic word_t round(input accum_t x);
        accum_t w_max;
        accum_t w_min;
        w_max = accum_t'((1 <<< (WORD_SIZE-1)) - 1);
        w_min = -accum_t'(1 <<< (WORD_SIZE-1));
        if (x > w_max)
            return word_t'(w_max);
        else if (x < w_min)
            return word_t'(w_min);
        else
            return word_t'(x);
    endfunction

    function automatic accum_t extend(input prod_t p);
        return {{(ACCUM_SIZE-PRODUCT_SIZE){p[PRODUCT_SIZE-1]}}, p};
    endfunction

endpackage

// File: rtl/fir_section_if.sv
// Sample/result handshake and coefficient write port of the FIR section.
interface fir_section_if #(
    parameter int TAPS = 8
);
    import fir_section_pkg::*;

    localparam int AW = $clog2(TAPS);

    accum_t          inData;
    logic            inValid;
    logic            inReady;
    logic            coefWrite;
    logic [AW-1:0]   coefAddr;
    word_t           coefData;
    accum_t          outData;
    logic            outValid;

    modport master (
        output inData, inValid, coefWrite, coefAddr, coefData,
        input  inReady, outData, outValid
    );

    modport slave (
        input  inData, inValid, coefWrite, coefAddr, coefData,
        output inReady, outData, outValid
    );

endinterface

// File: rtl/fir_section_mult.sv
// Shared signed multiplier of the IIR/FIR sections: full product rescaled by FRAC_BITS.
module fir_section_mult
    import fir_section_pkg::*;
(
    input  word_t i_a,
    input  word_t i_b,
    output prod_t o_p
);

    logic signed [2*WORD_SIZE-1:0] w_full;

    assign w_full = i_a * i_b;
    // The rescaled product always fits PRODUCT_SIZE, so dropping the top bits is lossless.
    assign o_p    = prod_t'(w_full >>> FRAC_BITS);

endmodule

// File: rtl/fir_section.sv
// Transversal FIR section: one sample in, TAPS multiply-accumulates on a single
// shared multiplier, one result out per TAPS+3 clocks.
module fir_section
    import fir_section_pkg::*;
#(
    parameter int TAPS      = 8,
    parameter int LOG2_GAIN = 0
) (
    input  logic          inClock,
    input  logic          reset,
    fir_section_if.slave  bus
);

    localparam int AW = $clog2(TAPS);

    state_t          r_state;
    state_t          w_nstate;
    word_t           r_dly  [TAPS];
    word_t           r_coef [TAPS];
    logic [AW-1:0]   r_ptr;
    logic [AW-1:0]   r_tap;
    logic [AW-1:0]   w_rdidx;
    word_t           r_fx;
    word_t           r_fh;
    prod_t           w_prod;
    accum_t          r_acc;
    accum_t          r_outData;
    logic            r_outValid;
    logic            w_last_tap;

    fir_section_mult u_mult (
        .i_a (r_fx),
        .i_b (r_fh),
        .o_p (w_prod)
    );

    assign w_last_tap = (r_tap == AW'(TAPS-1));

    // x[n-k] lives at (ptr-k) mod TAPS; the modulo-2^AW intermediate is harmless
    // because the final index is always below TAPS.
    always_comb begin
        w_rdidx = r_ptr - r_tap;
        if (r_ptr < r_tap)
            w_rdidx = r_ptr + AW'(TAPS) - r_tap;
    end

    always_ff @(posedge inClock or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            ST_IDLE:  if (bus.inValid) w_nstate = ST_MAC;
            ST_MAC:   if (w_last_tap)  w_nstate = ST_FLUSH;
            ST_FLUSH: w_nstate = ST_OUT;
            ST_OUT:   w_nstate = ST_IDLE;
            default:  w_nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge inClock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_dly[i]  <= '0;
                r_coef[i] <= '0;
            end
            r_ptr      <= '0;
            r_tap      <= '0;
            r_fx       <= '0;
            r_fh       <= '0;
            r_acc      <= '0;
            r_outData  <= '0;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    // Coefficients change only between samples, never under a running MAC.
                    if (bus.coefWrite && (int'(bus.coefAddr) < TAPS))
                        r_coef[bus.coefAddr] <= bus.coefData;
                    if (bus.inValid) begin
                        r_dly[r_ptr] <= round(bus.inData);
                        r_acc        <= '0;
                        r_tap        <= '0;
                    end
                end
                ST_MAC: begin
                    r_fx  <= r_dly[w_rdidx];
                    r_fh  <= r_coef[r_tap];
                    // Factors for tap k land this edge; the product on w_prod is tap k-1.
                    if (r_tap != '0)
                        r_acc <= r_acc + extend(w_prod);
                    r_tap <= r_tap + AW'(1);
                end
                ST_FLUSH: begin
                    r_acc <= r_acc + extend(w_prod);
                end
                ST_OUT: begin
                    r_outData  <= r_acc >>> LOG2_GAIN;
                    r_outValid <= 1'b1;
                    r_ptr      <= w_ptr_next(r_ptr);
                end
                default: ;
            endcase
        end
    end

    function automatic logic [AW-1:0] w_ptr_next(input logic [AW-1:0] p);
        return (p == AW'(TAPS-1)) ? '0 : p + AW'(1);
    endfunction

    assign bus.inReady  = (r_state == ST_IDLE);
    assign bus.outData  = r_outData;
    assign bus.outValid = r_outValid;

endmodule

// File: tb/tb_fir_section.sv
// Directed bench for fir_section: stimulus pushes hand-computed results into a
// scoreboard queue; a monitor pops and checks value and latency on each outValid.
module tb_fir_section;
    import fir_section_pkg::*;

    localparam int TAPS = 8;
    localparam int AW   = $clog2(TAPS);
    localparam int ONE  = 1 << FRAC_BITS;

    typedef struct {
        accum_t val;
        int     t;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_t = -1;
    bit   bp_on  = 0;
    exp_t sb[$];

    fir_section_if #(.TAPS(TAPS)) bus ();

    fir_section #(.TAPS(TAPS), .LOG2_GAIN(0)) dut (
        .inClock (clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Monitor: every outValid must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.outValid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", longint'(bus.outData), -999999);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", longint'(bus.outData), longint'(e.val));
                    chk("out_latency", longint'(cyc - e.t), TAPS + 2);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        last_t = -1;
    endtask

    task automatic wr_coef(input int k, input word_t h);
        bus.coefWrite = 1'b1;
        bus.coefAddr  = AW'(k);
        bus.coefData  = h;
        @(posedge clk);
        #1 bus.coefWrite = 1'b0;
    endtask

    // Offer one sample; on the accepting edge push its expected result.
    task automatic send(input accum_t x, input bit push, input accum_t e);
        int   w;
        exp_t tmp;
        w = 0;
        bus.inValid = 1'b1;
        bus.inData  = x;
        while (!bus.inReady && w < 50) begin
            @(posedge clk);
            #1 w++;
        end
        if (!bus.inReady) begin
            chk("xfer_timeout", w, 0);
            bus.inValid = 1'b0;
            return;
        end
        if (push) begin
            tmp.val = e;
            tmp.t   = cyc + 1;
            sb.push_back(tmp);
        end
        if (bp_on && last_t >= 0)
            chk("xfer_gap", longint'(cyc + 1 - last_t), TAPS + 3);
        last_t = cyc + 1;
        @(posedge clk);
        #1 bus.inValid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk);
            #1 w++;
        end
        chk("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    longint ovf_exp[8] = '{262128, 524256, 786384, 1048512,
                           -786512, -524384, -262256, -128};

    initial begin
        bus.inValid   = 1'b0;
        bus.inData    = '0;
        bus.coefWrite = 1'b0;
        bus.coefAddr  = '0;
        bus.coefData  = '0;
        rst_n         = 1'b0;
        #3;
        chk("rst_out_data", longint'(bus.outData), 0);
        chk("rst_out_valid", bus.outValid, 0);
        chk("rst_in_ready", bus.inReady, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Impulse response: h[k] = (k+1)/16.
        for (int k = 0; k < TAPS; k++) wr_coef(k, word_t'((k + 1) * ONE / 16));
        send(accum_t'(ONE), 1, accum_t'(ONE / 16));
        for (int i = 1; i < 10; i++)
            send('0, 1, (i < TAPS) ? accum_t'((i + 1) * ONE / 16) : accum_t'(0));
        drain();

        // Step response settling across pointer wrap: h = 1/8, x = 1/2.
        do_reset();
        for (int k = 0; k < TAPS; k++) wr_coef(k, word_t'(ONE / 8));
        for (int i = 0; i < 20; i++)
            send(accum_t'(ONE / 2), 1, accum_t'(((i < TAPS) ? i + 1 : TAPS) * ONE / 16));
        drain();

        // Back-pressure: inValid held high, identity filter, sequence-numbered samples.
        do_reset();
        wr_coef(0, word_t'(ONE));
        bp_on = 1;
        for (int i = 1; i <= 12; i++) send(accum_t'(i * 111), 1, accum_t'(i * 111));
        bp_on = 0;
        drain();

        // Coefficient write during MAC is ignored.
        do_reset();
        wr_coef(0, word_t'(ONE));
        send(accum_t'(ONE), 1, accum_t'(ONE));
        wr_coef(0, '0);
        wr_coef(0, '0);
        send(accum_t'(ONE), 1, accum_t'(ONE));
        drain();

        // Write and transfer on the same IDLE edge: new h[0]=2 applies to this sample.
        bus.coefWrite = 1'b1;
        bus.coefAddr  = '0;
        bus.coefData  = word_t'(2 * ONE);
        send(accum_t'(ONE), 1, accum_t'(2 * ONE));
        bus.coefWrite = 1'b0;
        drain();

        // Reset four clocks into MAC: immediate clear, no result, cleared coefficients.
        send(accum_t'(ONE), 0, '0);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_data", longint'(bus.outData), 0);
        chk("midrst_out_valid", bus.outValid, 0);
        chk("midrst_in_ready", bus.inReady, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        last_t = -1;
        repeat (15) @(posedge clk);
        #1;
        send(accum_t'(ONE), 1, '0);
        drain();

        // Overflow: max coefficients, saturating input, accumulator wraps.
        do_reset();
        for (int k = 0; k < TAPS; k++) wr_coef(k, word_t'(16'h7FFF));
        for (int i = 0; i < TAPS; i++) send(accum_t'(21'h0FFFFF), 1, accum_t'(ovf_exp[i]));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_section.md
Name: fir_section

Overview:
- Time-multiplexed all-zero (transversal) filter section. It is the feed-forward counterpart of the biquad IIR section.
- Typical uses: the inverse/equalising filter of an IIR cascade, or a standalone pre-filter ahead of the FFT.
- One shared signed multiplier serves all taps, one product per clock.
- Samples arrive over a valid/ready handshake; each result is flagged by a one-cycle valid pulse.

Parameters:
- TAPS, 8: number of taps N, range 2..64; also sizes the delay line and the coefficient RAM.
- LOG2_GAIN, 0: arithmetic right shift applied to the final sum; attenuation is 2^-LOG2_GAIN.

Ports:
- inClock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset; the block is in reset while this is 0.
- inData  in  ACCUM_SIZE  signed input sample; rounded to WORD_SIZE on capture.
- inValid  in  1  inData is valid.
- inReady  out  1  block can accept a sample.
- coefWrite  in  1  coefficient write strobe.
- coefAddr  in  clog2(TAPS)  tap index k.
- coefData  in  WORD_SIZE  signed coefficient h[k], same fixed-point format as the IIR coefficients.
- outData  out  ACCUM_SIZE  signed filter output y[n].
- outValid  out  1  one-cycle pulse; outData holds a new result.

Behaviour:
- Reset (reset=0, asynchronous), applied immediately:
  - state=IDLE; outData=0, outValid=0, inReady=1.
  - Accumulator, all delay-line words and all coefficients cleared to 0; write pointer=0.
  - Reset asserted mid-computation aborts it; no outValid is produced.
- Transfer: a sample is taken when inValid and inReady are both 1 at a rising edge.
  - inReady=1 only in IDLE; inValid outside IDLE is ignored and no sample is lost.
- FSM: IDLE -> MAC -> FLUSH -> OUT -> IDLE.
  - IDLE, on transfer: write round(inData) into the circular delay line at the pointer position; the newest sample becomes x[n]. Clear the accumulator, set tap=0, go to MAC.
  - MAC, one cycle per tap, k=0..TAPS-1:
    - Factor registers load x[n-k] and h[k].
    - From k>=1, accumulator += extended product of tap k-1.
    - After k=TAPS-1, go to FLUSH.
  - FLUSH: accumulator += product of tap TAPS-1.
  - OUT: outData <= accumulator >>> LOG2_GAIN; outValid=1 for exactly this cycle; go to IDLE.
- Latency: outValid rises TAPS+2 clocks after the transfer edge.
  - Throughput is one sample per TAPS+3 clocks.
  - inReady returns to 1 in the cycle after OUT.
- Delay line:
  - The pointer wraps from TAPS-1 to 0.
  - x[n-k] is read at (pointer-k) mod TAPS.
  - Entries older than N samples are overwritten, so the response to any input history equals the textbook N-tap FIR result.
- Arithmetic:
  - Product width is PRODUCT_SIZE, sign-extended to ACCUM_SIZE.
  - Accumulation wraps in two's complement with no saturation.
  - Input rounding uses the shared round() rule.
- Coefficients:
  - A write is committed at the edge only when state=IDLE; coefWrite in any other state is ignored.
  - A write and a sample transfer in the same IDLE cycle are both performed; the new coefficient applies to that sample.
- outData holds its value between pulses.

Decomposition:
- Shared FixedPoint package holds: WORD_SIZE, ACCUM_SIZE, PRODUCT_SIZE, FRAC_BITS, round(), extend().
- Local to this block: FSM state encoding.
- One sub-module: the existing shared signed multiplier (IirMultiplier), instantiated once and combinational from registered factors.
- Delay line and coefficient RAM are inline register arrays; no further sub-modules.

Test Plan (ONE = 1<<FRAC_BITS, TAPS=8, LOG2_GAIN=0):
- Impulse response: write h[k]=(k+1)*ONE/16, feed ONE followed by 9 zeros -> outputs (k+1)*ONE/16 for k=0..7, then 0, 0; each outValid exactly 10 clocks after its transfer edge.
- Wrap-around: h all ONE/8, feed constant ONE/2 for 20 samples -> outputs ramp ONE/16, 2*ONE/16, ..., settling at ONE/2 from sample 8 onward, stable across pointer wrap.
- Back-pressure: hold inValid=1 continuously -> inReady low for 10 of every 11 clocks, exactly one transfer per 11 clocks, no sample dropped or duplicated (sequence-numbered inputs checked against a model).
- Coefficient write while busy: write h[0]=ONE in IDLE, feed ONE, during MAC write h[0]=0 -> result ONE; the next impulse also gives ONE, because the busy write was ignored.
- Reset mid-operation: drop reset 4 clocks into MAC -> outData=0 and outValid=0 immediately, inReady=1; after release an impulse with all-zero coefficients yields 0.
- Overflow wrap: h all 0x7FFF-equivalent max, inputs max positive for 8 samples -> accumulator wraps in two's complement, matching a bit-accurate model (no saturation).
